// File: rtl/mips_pkg.sv
// mips_pkg: opcode, funct and ALU-op constants shared by the MIPS functional units.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_XOR = 4'd13;
endpackage

// File: rtl/mips_dmem.sv
// mips_dmem: word-addressed data memory, combinational read, clocked write, async clear.
module mips_dmem #(
  parameter int NMEM = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(NMEM);
  logic [31:0]   mem [NMEM];
  logic [AW-1:0] idx;
  // Truncating the shifted address drops the byte offset and wraps high bits.
  assign idx = AW'(addr >> 2);
  assign rdata = rd ? mem[idx] : 32'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < NMEM; i++) mem[i] <= 32'd0;
    else if (wr)
      mem[idx] <= wdata;
endmodule

// File: rtl/mips_func_units.sv
// mips_func_units: ID decode control, EX ALU and MEM data memory of the 5-stage MIPS pipeline.
import mips_pkg::*;
module mips_func_units #(
  parameter int NMEM = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic        regdst,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrc,
  output logic        jump,
  output logic [3:0]  aluctl,
  input  logic [3:0]  alu_op,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [31:0] alu_out,
  output logic        alu_zero,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata
);
  always_comb begin
    regdst    = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrc    = 1'b0;
    jump      = 1'b0;
    aluctl    = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        // Unknown funct (including the NOP word) leaves every control low.
        case (funct)
          FN_ADD:  aluctl = ALU_ADD;
          FN_SUB:  aluctl = ALU_SUB;
          FN_AND:  aluctl = ALU_AND;
          FN_OR:   aluctl = ALU_OR;
          FN_XOR:  aluctl = ALU_XOR;
          FN_NOR:  aluctl = ALU_NOR;
          FN_SLT:  aluctl = ALU_SLT;
          default: aluctl = ALU_ADD;
        endcase
        regdst   = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT};
        regwrite = regdst;
      end
      OP_LW: begin
        alusrc   = 1'b1;
        memread  = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      OP_SW: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      OP_BEQ: begin
        branch_eq = 1'b1;
        aluctl    = ALU_SUB;
      end
      OP_BNE: begin
        branch_ne = 1'b1;
        aluctl    = ALU_SUB;
      end
      OP_ADDI: begin
        alusrc   = 1'b1;
        regwrite = 1'b1;
      end
      OP_SLTI: begin
        alusrc   = 1'b1;
        regwrite = 1'b1;
        aluctl   = ALU_SLT;
      end
      OP_J:    jump = 1'b1;
      default: aluctl = ALU_ADD;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_SLT: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      ALU_NOR: alu_out = ~(alu_a | alu_b);
      ALU_XOR: alu_out = alu_a ^ alu_b;
      default: alu_out = 32'd0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  mips_dmem #(.NMEM(NMEM)) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .addr  (mem_addr),
    .rd    (mem_rd),
    .wr    (mem_wr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_mips_func_units.sv
// tb_mips_func_units: directed checks of decode, ALU and data memory with hand-computed results.
module tb_mips_func_units;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump;
  logic [3:0]  aluctl, alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_func_units #(.NMEM(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .regdst(regdst), .branch_eq(branch_eq), .branch_ne(branch_ne), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite), .alusrc(alusrc),
    .jump(jump), .aluctl(aluctl), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // {opcode, funct, {regdst,beq,bne,memread,memwrite,memtoreg,regwrite,alusrc,jump}, aluctl}
  localparam logic [24:0] DEC_TAB [13] = '{
    {6'b100011, 6'b000000, 9'b000101110, 4'd2},
    {6'b101011, 6'b000000, 9'b000010010, 4'd2},
    {6'b000100, 6'b000000, 9'b010000000, 4'd6},
    {6'b000101, 6'b000000, 9'b001000000, 4'd6},
    {6'b001000, 6'b000000, 9'b000000110, 4'd2},
    {6'b001010, 6'b000000, 9'b000000110, 4'd7},
    {6'b000010, 6'b101010, 9'b000000001, 4'd2},
    {6'b111111, 6'b100010, 9'b000000000, 4'd2},
    {6'b000000, 6'b101010, 9'b100000100, 4'd7},
    {6'b000000, 6'b100000, 9'b100000100, 4'd2},
    {6'b000000, 6'b100010, 9'b100000100, 4'd6},
    {6'b000000, 6'b100110, 9'b100000100, 4'd13},
    {6'b000000, 6'b000000, 9'b000000000, 4'd2}
  };

  // {op, a, b, expected out}
  localparam logic [99:0] ALU_TAB [12] = '{
    {4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
    {4'd6,  32'h00000005, 32'h00000007, 32'hFFFFFFFE},
    {4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
    {4'd7,  32'h00000001, 32'hFFFFFFFF, 32'h00000000},
    {4'd7,  32'h80000000, 32'h7FFFFFFF, 32'h00000001},
    {4'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0},
    {4'd1,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0},
    {4'd13, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00},
    {4'd12, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F},
    {4'd2,  32'h12345678, 32'h11111111, 32'h23456789},
    {4'd6,  32'h00000007, 32'h00000007, 32'h00000000},
    {4'd3,  32'h00000005, 32'h00000007, 32'h00000000}
  };

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_addr = a; mem_wdata = d; mem_wr = 1'b1;
    @(posedge clk); #1;
    mem_wr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    opcode = 6'h0; funct = 6'h0; alu_op = 4'd0; alu_a = 32'h0; alu_b = 32'h0;
    #1;
    for (int i = 0; i < 4; i++) begin
      mem_addr = 32'(i * 4); #1;
      n_cmp++;
      if (mem_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL reset_read[%0d]: got %h want 00000000", i, mem_rdata);
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_decode;
    for (int i = 0; i < 13; i++) begin
      opcode = DEC_TAB[i][24:19]; funct = DEC_TAB[i][18:13]; #1;
      n_cmp++;
      if ({regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump} !== DEC_TAB[i][12:4]
          || aluctl !== DEC_TAB[i][3:0]) begin
        n_err++;
        $display("FAIL decode op=%b fn=%b: got ctl=%b alu=%0d want ctl=%b alu=%0d", opcode, funct,
          {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump}, aluctl,
          DEC_TAB[i][12:4], DEC_TAB[i][3:0]);
      end
    end
  endtask

  task automatic test_alu;
    for (int i = 0; i < 12; i++) begin
      alu_op = ALU_TAB[i][99:96]; alu_a = ALU_TAB[i][95:64]; alu_b = ALU_TAB[i][63:32]; #1;
      n_cmp++;
      if (alu_out !== ALU_TAB[i][31:0]) begin
        n_err++;
        $display("FAIL alu_out[%0d] op=%0d: got %h want %h", i, alu_op, alu_out, ALU_TAB[i][31:0]);
      end
      n_cmp++;
      if (alu_zero !== (ALU_TAB[i][31:0] == 32'h0)) begin
        n_err++;
        $display("FAIL alu_zero[%0d]: got %b want %b", i, alu_zero, ALU_TAB[i][31:0] == 32'h0);
      end
    end
  endtask

  task automatic test_mem;
    wr_word(32'h10, 32'hDEADBEEF);
    mem_rd = 1'b1;
    mem_addr = 32'h10; #1;
    n_cmp++;
    if (mem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL mem_read_0x10: got %h want deadbeef", mem_rdata); end
    mem_addr = 32'h90; #1;
    n_cmp++;
    if (mem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL mem_wrap_0x90: got %h want deadbeef", mem_rdata); end
    mem_addr = 32'h13; #1;
    n_cmp++;
    if (mem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL mem_byte_off_0x13: got %h want deadbeef", mem_rdata); end
    mem_addr = 32'h14; #1;
    n_cmp++;
    if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL mem_neighbor_0x14: got %h want 00000000", mem_rdata); end
    mem_addr = 32'h10; mem_rd = 1'b0; #1;
    n_cmp++;
    if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL mem_rd_low: got %h want 00000000", mem_rdata); end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    mem_addr = 32'h8; mem_wdata = 32'h1234; mem_rd = 1'b1; mem_wr = 1'b1; #1;
    n_cmp++;
    if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL rw_pre_edge: got %h want 00000000", mem_rdata); end
    @(posedge clk); #1;
    mem_wr = 1'b0;
    n_cmp++;
    if (mem_rdata !== 32'h1234) begin n_err++; $display("FAIL rw_post_edge: got %h want 00001234", mem_rdata); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 4; i++) wr_word(32'(i * 4), 32'hA0 + 32'(i));
    mem_rd = 1'b1; mem_addr = 32'hC; #1;
    n_cmp++;
    if (mem_rdata !== 32'hA3) begin n_err++; $display("FAIL fill_word3: got %h want 000000a3", mem_rdata); end
    @(negedge clk); #2;
    rst = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      mem_addr = 32'(i * 4); #0.5;
      n_cmp++;
      if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL async_clear[%0d]: got %h want 00000000", i, mem_rdata); end
    end
    mem_addr = 32'h0; mem_wdata = 32'h5555AAAA; mem_wr = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL write_in_reset: got %h want 00000000", mem_rdata); end
    mem_wr = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++;
    if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL after_reset: got %h want 00000000", mem_rdata); end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_alu;
    test_mem;
    test_same_cycle;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
